exec_alu_hilo: RTL



---
 rtl/exec_alu_hilo.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/exec_alu_hilo.sv
// rtl/exec_alu_hilo.sv - execute-stage ALU with HI/LO registers and sequential divider
//
// Purpose:
//   Single-cycle combinational ALU for all non-divide operations, plus a
//   32-iteration restoring divider that writes the architectural HI
//   (remainder) and LO (quotient) registers. While a divide is in flight,
//   stall freezes the upstream pipeline.
//
// Optional feature macro: EXEC_DIVU_EN
//   Defined   : div_unsigned=1 at divide start gives an unsigned divide.
//   Undefined : div_unsigned is ignored and every divide is signed.
//
// Ports:
//   clock        in   1  pipeline clock, rising edge
//   reset        in   1  synchronous, active-high
//   valid_in     in   1  EX-stage instruction valid (low = bubble)
//   alu_op       in   4  operation code
//   op_a         in  32  rs operand
//   op_b         in  32  rt operand or extended immediate
//   shamt        in   5  shift amount for sll/sra
//   div_unsigned in   1  DIVU select (EXEC_DIVU_EN builds only)
//   result       out 32  combinational ALU result
//   undef_op     out  1  valid instruction with an undefined opcode
//   stall        out  1  freeze IF/ID/EX pipeline registers
//   hi           out 32  HI register (remainder)
//   lo           out 32  LO register (quotient)
//   div_busy     out  1  divider in the RUN state

module exec_alu_hilo #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  alu_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  shamt,
  input  logic        div_unsigned,
  output logic [31:0] result,
  output logic        undef_op,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_busy
);

  localparam logic [3:0] ALU_add     = 4'd0;
  localparam logic [3:0] ALU_sub     = 4'd1;
  localparam logic [3:0] ALU_AND     = 4'd2;
  localparam logic [3:0] ALU_OR      = 4'd3;
  localparam logic [3:0] ALU_slt     = 4'd4;
  localparam logic [3:0] ALU_sll     = 4'd5;
  localparam logic [3:0] ALU_sra     = 4'd6;
  localparam logic [3:0] ALU_slli    = 4'd7;
  localparam logic [3:0] ALU_rs_pass = 4'd8;
  localparam logic [3:0] ALU_div     = 4'd9;
  localparam logic [3:0] ALU_undef   = 4'd15;

  localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic [31:0] r_rem;   // partial remainder
  logic [31:0] r_quo;   // dividend bits shift out the top, quotient bits shift in
  logic [31:0] r_dvs;   // divisor magnitude
  logic        r_qneg;
  logic        r_rneg;

  logic [31:0] w_result;
  logic        w_undef;
  logic        w_start;
  logic        w_uns;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quo_nxt;

  // ---------------------------------------------------------------------
  // Combinational ALU; independent of valid_in
  // ---------------------------------------------------------------------
  always_comb begin
    w_result = 32'd0;
    w_undef  = 1'b0;
    case (alu_op)
      ALU_add:     w_result = op_a + op_b;
      ALU_sub:     w_result = op_a - op_b;
      ALU_AND:     w_result = op_a & op_b;
      ALU_OR:      w_result = op_a | op_b;
      ALU_slt:     w_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      ALU_sll:     w_result = op_b << shamt;
      ALU_sra:     w_result = $signed(op_b) >>> shamt;
      ALU_slli:    w_result = {op_b[15:0], 16'd0};
      ALU_rs_pass: w_result = op_a;
      ALU_div:     w_result = 32'd0;
      ALU_undef:   w_undef  = 1'b1;
      default:     w_undef  = 1'b1;
    endcase
  end

  assign result   = w_result;
  assign undef_op = valid_in & w_undef;

  // ---------------------------------------------------------------------
  // Divider operand preparation
  // ---------------------------------------------------------------------
`ifdef EXEC_DIVU_EN
  assign w_uns = div_unsigned;
`else
  // Signed-only build: the select input is read but has no effect.
  assign w_uns = 1'b0 & div_unsigned;
`endif

  assign w_start  = valid_in && (alu_op == ALU_div);
  assign w_sign_a = ~w_uns & op_a[31];
  assign w_sign_b = ~w_uns & op_b[31];
  assign w_abs_a  = w_sign_a ? (~op_a + 32'd1) : op_a;
  assign w_abs_b  = w_sign_b ? (~op_b + 32'd1) : op_b;

  // One restoring step: remainder never exceeds the divisor, so 33 bits suffice.
  assign w_trial   = {r_rem, r_quo[31]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? 32'(w_trial - {1'b0, r_dvs}) : w_trial[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};

  // ---------------------------------------------------------------------
  // Divider FSM and HI/LO
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= 5'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvs   <= 32'd0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (op_b == 32'd0) begin
              // Divide by zero completes immediately without stalling.
              r_lo <= 32'hFFFF_FFFF;
              r_hi <= op_a;
            end else begin
              r_rem   <= 32'd0;
              r_quo   <= w_abs_a;
              r_dvs   <= w_abs_b;
              r_qneg  <= w_sign_a ^ w_sign_b;
              r_rneg  <= w_sign_a;
              r_count <= 5'd0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_count == LAST_CNT) begin
            r_lo    <= r_qneg ? (~w_quo_nxt + 32'd1) : w_quo_nxt;
            r_hi    <= r_rneg ? (~w_rem_nxt + 32'd1) : w_rem_nxt;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_count <= r_count + 5'd1;
          end
        end
        S_DONE: begin
          // The stalled divide is still on the inputs; do not restart it.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the start cycle itself, so it is decoded from the
  // current state and inputs rather than registered.
  assign stall = ~reset &
                 (((r_state == S_IDLE) && w_start && (op_b != 32'd0)) ||
                  (r_state == S_RUN));

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_busy = r_busy;

endmodule
